force_result_collector: RTL

Downstream consumer of the first-order RL LJ pipeline force stream. It captures every valid {Z,Y,X} force triple into on-chip storage during a run. When the pipeline signals done, it drains the captured words in order over a valid/ready stream for host/readback logic. It also reports word count, overflow and completion status for on-board test.

---
 rtl/force_result_collector.sv | 125 ++++++++++++
 1 files changed

// File: rtl/force_result_collector.sv
// rtl/force_result_collector.sv - captures LJ force triples during a run and drains them in order over a valid/ready stream
module force_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 10000,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]   LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]   LJ_Force_Z,
  input  logic                    forceoutput_valid,
  input  logic                    done,
  output logic [3*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    collect_done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t state, next_state;

  logic [3*DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_next;
  logic                    arm;
  logic                    full;
  logic                    wr_en;
  logic                    drop;
  logic                    rd_issue;
  logic                    last_accept;

  assign arm         = start && (state == IDLE || state == FINISHED);
  assign full        = (word_count == DEPTH_CNT);
  assign wr_en       = (state == CAPTURE) && forceoutput_valid && !full;
  assign drop        = (state == CAPTURE) && forceoutput_valid && full;
  assign count_next  = word_count + {{ADDR_WIDTH{1'b0}}, wr_en};
  // A read may be issued whenever the output register is empty or being emptied this cycle.
  assign rd_issue    = (state == DRAIN) && (!out_valid || out_ready) && (rd_ptr < word_count);
  assign last_accept = (state == DRAIN) && out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = CAPTURE;
      end
      CAPTURE: begin
        // Count includes a triple arriving together with done.
        if (done) next_state = (count_next != '0) ? DRAIN : FINISHED;
      end
      DRAIN: begin
        if (last_accept) next_state = FINISHED;
      end
      FINISHED: begin
        if (start) next_state = CAPTURE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == CAPTURE) || (state == DRAIN);
    collect_done = (state == FINISHED);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count[ADDR_WIDTH-1:0]] <= {LJ_Force_Z, LJ_Force_Y, LJ_Force_X};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (arm) begin
      word_count <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (wr_en) word_count <= count_next;
      if (drop)  overflow   <= 1'b1;
      if (rd_issue) begin
        out_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        out_valid <= 1'b1;
        out_last  <= (rd_ptr == word_count - ONE);
        rd_ptr    <= rd_ptr + ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
